fetch_prefetch_top: RTL and testbench
=====================================

Name: fetch_prefetch_top

Overview:
Parametrised next-generation RISC-V fetch stage. It decouples PC generation from instruction delivery with a DEPTH-entry prefetch queue and an instruction memory that may have variable latency, using a req/rvalid handshake. Redirects (branch/jump) are handled by discarding stale in-flight responses. Wrong-path ECALL halts are recoverable. The block sits between the instruction memory and the IF/ID pipeline register consumed by decode.

Parameters:
XLEN, 32, datapath/PC width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
MAX_OUT, 2, maximum outstanding imem requests (1..DEPTH)
RESET_PC, 32'h0, PC after reset
IMEM_AW, 11, word-address width of imem

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stall  in  1  hold IF/ID (decode not ready); includes LWCP stall
flush  in  1  redirect: discard queue and in-flight responses, load target
target_addr  in  XLEN  redirect PC, valid with flush
imem_req  out  1  request strobe; accepted the same cycle
imem_addr  out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]
imem_rvalid  in  1  response valid; responses return in order, latency >=1
imem_rdata  in  XLEN  instruction word
if_id_valid  out  1  IF/ID holds a real instruction
if_id_inst  out  XLEN  instruction (NOP when invalid)
if_id_pc  out  XLEN  instruction PC
if_id_pc_inc  out  XLEN  if_id_pc+4
if_id_hlt  out  1  instruction is ECALL
halted  out  1  fetch stopped on ECALL

Behaviour:
- Reset (rst_n=0 at posedge): fetch_pc=resp_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; halted=0; if_id_valid=0, if_id_inst=NOP (ADDI x0,x0,0), if_id_pc=RESET_PC, if_id_pc_inc=RESET_PC+4, if_id_hlt=0. Reset mid-request: responses arriving after reset are not dropped. The integration rule is that imem is reset together with this block.
- Issue: imem_req = ~halted & ~flush & (outstanding<MAX_OUT) & (count+outstanding<DEPTH). On issue, fetch_pc += 4. Queue overflow is therefore impossible.
- Response: on imem_rvalid, if drop_cnt>0, decrement drop_cnt and discard. Otherwise push {resp_pc, imem_rdata}, and resp_pc += 4. outstanding tracks issue minus rvalid; both may occur in one cycle (net 0).
- Halt: a pushed word with opcode ECALL (7'b1110011) sets halted in the next cycle. Entries already queued still drain.
- Output: when ~stall, IF/ID loads the queue head if non-empty (pop; valid=1, hlt=opcode==ECALL, pc_inc=pc+4). Otherwise it loads a bubble (valid=0, inst=NOP, hlt=0; pc/pc_inc hold). When stall=1, IF/ID and the queue head hold. Push to a full queue cannot occur; push and pop in the same cycle is permitted, including when the queue is full.
- Pass-through: a response arriving into an empty queue with ~stall is visible at IF/ID in the next cycle. Minimum fetch-to-IF/ID latency is imem latency + 1.
- Flush (overrides stall and everything else):
  - queue cleared
  - fetch_pc=resp_pc=target_addr
  - halted=0
  - IF/ID loads the bubble
  - drop_cnt = outstanding - (imem_rvalid & drop_cnt==0 ? 1 : 0) + drop-state decrement
  - no issue in the flush cycle; the first issue at target_addr is in the next cycle.
- Flush with halted=1 resumes fetch at the target (wrong-path ECALL recovery).
- Widths: PC arithmetic wraps modulo 2^XLEN. Counters are clog2(DEPTH+1) and clog2(MAX_OUT+1) bits wide.

Decomposition:
- In common_params:
  - NOP constant
  - ECALL_i opcode enum
  - a fetch_entry_t packed struct {pc, inst}, parametrised by XLEN via the BITS constant
- Sub-module fetch_fifo: synchronous FIFO, DEPTH entries, with push/pop/clear, full/empty/count, and read-during-write on full allowed.

Test Plan:
- Reset, 1-cycle imem, stall=0 -> IF/ID PCs 0,4,8,12 on consecutive cycles from cycle 3. if_id_pc_inc tracks +4. No bubbles after fill.
- 3-cycle imem, DEPTH=4, MAX_OUT=2 -> imem_req never exceeds 2 outstanding. Queue count stays <=4. No instruction is lost or duplicated over 100 words.
- stall held 10 cycles with a 1-cycle imem -> queue fills to 4 and imem_req deasserts. Release stall -> PCs resume in order without a gap.
- flush with target 0x100 while 2 requests are outstanding (3-cycle latency) -> both stale responses are dropped. The next valid IF/ID PC is 0x100 with if_id_inst=mem[0x40].
- ECALL at 0x10 -> halted=1 and no req after 0x10 (beyond those already outstanding). IF/ID shows 0x10 with hlt=1, then bubbles.
- ECALL at 0x10 followed by flush to 0x40 before it drains -> halted clears and fetch resumes at 0x40. Assert reset mid-stream -> all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/fetch_prefetch_pkg.sv
// Shared constants and types for the fetch stage: NOP encoding, opcodes of
// interest and the {pc, inst} entry carried through the prefetch queue.
package common_params;

  localparam int BITS = 32;

  // ADDI x0, x0, 0
  localparam logic [BITS-1:0] NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_IMM_i = 7'b0010011,
    ECALL_i  = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [BITS-1:0] pc;
    logic [BITS-1:0] inst;
  } fetch_entry_t;

  function automatic logic is_ecall(input logic [6:0] opc);
    return opc == ECALL_i;
  endfunction

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Synchronous prefetch FIFO; a push into a full queue is accepted when a pop
// happens in the same cycle.
module fetch_fifo
  import common_params::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_prefetch_top.sv
// Fetch stage: PC generation with bounded outstanding imem requests, a prefetch
// queue feeding IF/ID, and stale-response dropping after a redirect.
module fetch_prefetch_top
  import common_params::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter int              IMEM_AW  = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [XLEN-1:0]    target_addr,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               if_id_valid,
  output logic [XLEN-1:0]    if_id_inst,
  output logic [XLEN-1:0]    if_id_pc,
  output logic [XLEN-1:0]    if_id_pc_inc,
  output logic               if_id_hlt,
  output logic               halted
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              OW      = $clog2(MAX_OUT + 1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  fetch_entry_t    q_dout;
  fetch_entry_t    resp_entry;
  fetch_entry_t    head;
  logic            issue;
  logic            resp_drop;
  logic            resp_take;
  logic            bypass;
  logic            q_push;
  logic            q_pop;
  logic            deliver;

  // Queue occupancy plus in-flight requests never exceeds DEPTH, so every
  // accepted response is guaranteed a slot.
  assign issue     = ~halted & ~flush & (outstanding < OW'(MAX_OUT))
                   & ((int'(q_count) + int'(outstanding)) < DEPTH);
  assign imem_req  = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  assign resp_drop = imem_rvalid & (drop_cnt != '0);
  assign resp_take = imem_rvalid & (drop_cnt == '0) & ~flush;

  // An empty queue lets a fresh response go straight into IF/ID.
  assign bypass  = resp_take & q_empty & ~stall;
  assign q_push  = resp_take & ~bypass & (~q_full | q_pop);
  assign q_pop   = ~flush & ~stall & ~q_empty;
  assign deliver = bypass | q_pop;

  assign resp_entry.pc   = resp_pc;
  assign resp_entry.inst = imem_rdata;
  assign head            = q_empty ? resp_entry : q_dout;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .clear (flush),
    .din   (resp_entry),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Every request still in flight at a redirect belongs to the old path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      halted      <= 1'b0;
    end else begin
      outstanding <= outstanding + OW'(issue) - OW'(imem_rvalid);
      if (flush) begin
        fetch_pc <= target_addr;
        resp_pc  <= target_addr;
        halted   <= 1'b0;
        drop_cnt <= outstanding - OW'(imem_rvalid);
      end else begin
        if (issue)     fetch_pc <= fetch_pc + PC_STEP;
        if (resp_drop) drop_cnt <= drop_cnt - OW'(1);
        if (resp_take) begin
          resp_pc <= resp_pc + PC_STEP;
          if (is_ecall(imem_rdata[6:0])) halted <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_valid  <= 1'b0;
      if_id_inst   <= NOP;
      if_id_pc     <= RESET_PC;
      if_id_pc_inc <= RESET_PC + PC_STEP;
      if_id_hlt    <= 1'b0;
    end else if (flush || !stall) begin
      if (!flush && deliver) begin
        if_id_valid  <= 1'b1;
        if_id_inst   <= head.inst;
        if_id_pc     <= head.pc;
        if_id_pc_inc <= head.pc + PC_STEP;
        if_id_hlt    <= is_ecall(head.inst[6:0]);
      end else begin
        if_id_valid <= 1'b0;
        if_id_inst  <= NOP;
        if_id_hlt   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_top.sv
// Randomised bench for fetch_prefetch_top: an in-order variable-latency imem plus
// a queue-level reference model of the fetch stream checked every cycle.
module tb_fetch_prefetch_top;
  import common_params::*;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUT   = 2;
  localparam int          MEM_WORDS = 2048;
  localparam logic [31:0] RST_PC    = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target_addr = '0;
  logic        imem_req;
  logic [10:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_inc;
  logic        if_id_hlt;
  logic        halted;

  always #5 clk = ~clk;

  fetch_prefetch_top #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RST_PC),
    .IMEM_AW  (11)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .target_addr  (target_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_inst   (if_id_inst),
    .if_id_pc     (if_id_pc),
    .if_id_pc_inc (if_id_pc_inc),
    .if_id_hlt    (if_id_hlt),
    .halted       (halted)
  );

  typedef struct {
    int addr;
    int due;
    bit stale;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic [31:0] mem [MEM_WORDS];
  pend_t       pending[$];
  ent_t        mq[$];
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          model_ready = 0;

  logic [31:0] m_fetch;
  logic [31:0] m_resp;
  bit          m_halted;
  bit          e_valid;
  bit          e_hlt;
  logic [31:0] e_inst;
  logic [31:0] e_pc;
  logic [31:0] e_pc_inc;

  bit          s_valid;
  bit          s_hlt;
  bit          s_halted;
  bit          s_req;
  logic [31:0] s_inst;
  logic [31:0] s_pc;
  logic [31:0] s_pc_inc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fillMem(input bit with_ecalls);
    logic [31:0] w;
    for (int i = 0; i < MEM_WORDS; i++) begin
      w      = $urandom;
      w[6:0] = 7'b0010011;
      if (with_ecalls && $urandom_range(63, 0) == 0) w = 32'h0000_0073;
      mem[i] = w;
    end
  endtask

  // One clock cycle: drive inputs and imem response, compare, advance the model.
  task automatic applyStimulus(input bit rs, input bit st, input bit fl, input logic [31:0] tg);
    bit          exp_req;
    bit          got;
    logic [31:0] word;
    ent_t        ent;
    int          lat;
    @(negedge clk);
    rst_n       = rs;
    stall       = st;
    flush       = fl;
    target_addr = tg;
    if (rs && pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem[pending[0].addr];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_valid  = if_id_valid;
    s_inst   = if_id_inst;
    s_pc     = if_id_pc;
    s_pc_inc = if_id_pc_inc;
    s_hlt    = if_id_hlt;
    s_halted = halted;
    s_req    = imem_req;
    exp_req  = !m_halted && !fl && (pending.size() < MAX_OUT) && (mq.size() + pending.size() < DEPTH);
    if (model_ready) begin
      checkOutput("if_id_valid", 32'(s_valid), 32'(e_valid));
      checkOutput("if_id_inst", s_inst, e_inst);
      checkOutput("if_id_pc", s_pc, e_pc);
      checkOutput("if_id_pc_inc", s_pc_inc, e_pc_inc);
      checkOutput("if_id_hlt", 32'(s_hlt), 32'(e_hlt));
      checkOutput("halted", 32'(s_halted), 32'(m_halted));
      checkOutput("imem_req", 32'(s_req), 32'(exp_req));
      if (s_req && exp_req) checkOutput("imem_addr", 32'(imem_addr), 32'(m_fetch[12:2]));
    end
    if (!rs) begin
      pending.delete();
      mq.delete();
      m_fetch  = RST_PC;
      m_resp   = RST_PC;
      m_halted = 0;
      e_valid  = 0;
      e_inst   = NOP;
      e_pc     = RST_PC;
      e_pc_inc = RST_PC + 32'd4;
      e_hlt    = 0;
      model_ready = 1;
    end else begin
      got  = 0;
      word = imem_rdata;
      if (imem_rvalid) begin
        got = !pending[0].stale;
        void'(pending.pop_front());
      end
      if (fl) begin
        mq.delete();
        m_fetch  = tg;
        m_resp   = tg;
        m_halted = 0;
        foreach (pending[i]) pending[i].stale = 1'b1;
        e_valid = 0;
        e_inst  = NOP;
        e_hlt   = 0;
      end else begin
        if (exp_req) m_fetch = m_fetch + 32'd4;
        if (s_req) begin
          lat = $urandom_range(lat_max, lat_min);
          pending.push_back('{addr: int'(imem_addr), due: cyc + lat, stale: 1'b0});
        end
        if (got) begin
          mq.push_back('{pc: m_resp, inst: word});
          m_resp = m_resp + 32'd4;
          if (word[6:0] == 7'b1110011) m_halted = 1;
        end
        if (!st) begin
          if (mq.size() > 0) begin
            ent      = mq.pop_front();
            e_valid  = 1;
            e_inst   = ent.inst;
            e_pc     = ent.pc;
            e_pc_inc = ent.pc + 32'd4;
            e_hlt    = (ent.inst[6:0] == 7'b1110011);
          end else begin
            e_valid = 0;
            e_inst  = NOP;
            e_hlt   = 0;
          end
        end
      end
    end
    checkOutput("outstanding_bound", 32'(pending.size() <= MAX_OUT), 32'd1);
    @(posedge clk);
    cyc++;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 0, 0, '0);
  endtask

  initial begin
    bit          found;
    bit          saw_ecall;
    int          delivered;
    logic [31:0] last_pc;

    // Single-cycle imem streaming from reset
    fillMem(0);
    lat_min = 1; lat_max = 1;
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 0, 0, '0);
      if (k == 0) begin
        checkOutput("reset_valid", 32'(s_valid), 32'd0);
        checkOutput("reset_inst", s_inst, 32'h0000_0013);
        checkOutput("reset_pc_inc", s_pc_inc, 32'd4);
      end else if (k >= 2) begin
        checkOutput("stream_valid", 32'(s_valid), 32'd1);
        checkOutput("stream_pc", s_pc, 32'((k - 2) * 4));
        checkOutput("stream_pc_inc", s_pc_inc, 32'((k - 1) * 4));
      end
      if (k == 2) checkOutput("stream_inst0", s_inst, mem[0]);
    end

    // Hold decode for 10 cycles: queue fills and requests stop
    for (int k = 0; k < 10; k++) applyStimulus(1, 1, 0, '0);
    checkOutput("stall_req_off", 32'(s_req), 32'd0);
    checkOutput("stall_queue_full", 32'(mq.size()), 32'd4);
    for (int k = 0; k < 12; k++) applyStimulus(1, 0, 0, '0);

    // Three-cycle imem with random stalls, 100+ words
    doReset();
    lat_min = 3; lat_max = 3;
    delivered = 0;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1, ($urandom_range(3, 0) == 0), 0, '0);
      if (s_valid) delivered++;
    end
    checkOutput("words_delivered_ge_100", 32'(delivered >= 100), 32'd1);

    // Redirect to 0x100 with two requests in flight
    doReset();
    applyStimulus(1, 0, 0, '0);
    applyStimulus(1, 0, 0, '0);
    checkOutput("flush_two_outstanding", 32'(pending.size()), 32'd2);
    applyStimulus(1, 0, 1, 32'h100);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus(1, 0, 0, '0);
      if (s_valid) begin
        found = 1;
        checkOutput("flush_first_pc", s_pc, 32'h100);
        checkOutput("flush_first_inst", s_inst, mem[32'h40]);
      end
    end
    checkOutput("flush_first_found", 32'(found), 32'd1);

    // ECALL at 0x10 halts fetch
    mem[4] = 32'h0000_0073;
    lat_min = 1; lat_max = 1;
    doReset();
    saw_ecall = 0;
    last_pc   = '0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 0, 0, '0);
      if (s_valid) last_pc = s_pc;
      if (s_valid && s_pc == 32'h10 && s_hlt) saw_ecall = 1;
    end
    checkOutput("ecall_seen", 32'(saw_ecall), 32'd1);
    checkOutput("ecall_halted", 32'(s_halted), 32'd1);
    checkOutput("ecall_last_pc", last_pc, 32'h14);
    checkOutput("ecall_bubble", 32'(s_valid), 32'd0);

    // ECALL queued behind a stall, then a redirect to 0x40 recovers
    doReset();
    for (int k = 0; k < 8; k++) applyStimulus(1, 1, 0, '0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus(1, 0, 0, '0);
      foreach (mq[i]) if (mq[i].pc == 32'h10) found = 1;
    end
    checkOutput("ecall_queued", 32'(found), 32'd1);
    applyStimulus(1, 1, 0, '0);
    checkOutput("ecall_queued_halted", 32'(s_halted), 32'd1);
    applyStimulus(1, 1, 1, 32'h40);
    applyStimulus(1, 0, 0, '0);
    checkOutput("recover_halted_clear", 32'(s_halted), 32'd0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus(1, 0, 0, '0);
      if (s_valid) begin
        found = 1;
        checkOutput("recover_first_pc", s_pc, 32'h40);
        checkOutput("recover_first_inst", s_inst, mem[32'h10]);
      end
    end
    checkOutput("recover_found", 32'(found), 32'd1);

    // Reset mid-stream
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, '0);
    applyStimulus(0, 0, 0, '0);
    applyStimulus(1, 0, 0, '0);
    checkOutput("midreset_valid", 32'(s_valid), 32'd0);
    checkOutput("midreset_inst", s_inst, 32'h0000_0013);
    checkOutput("midreset_pc", s_pc, 32'h0);
    checkOutput("midreset_pc_inc", s_pc_inc, 32'h4);
    checkOutput("midreset_hlt", 32'(s_hlt), 32'd0);
    checkOutput("midreset_halted", 32'(s_halted), 32'd0);

    // Random traffic: variable latency, stalls, redirects, ECALLs, resets
    fillMem(1);
    lat_min = 1; lat_max = 4;
    doReset();
    applyStimulus(1, 0, 1, 32'hFFFF_FFF8);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(999, 0) < 3) begin
        applyStimulus(0, 0, 0, '0);
      end else begin
        applyStimulus(1, ($urandom_range(9, 0) < 3), ($urandom_range(99, 0) < 3),
                      {$urandom_range(32'hFFFF, 0), 16'h0} | {16'h0, 3'b000, 11'($urandom), 2'b00});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
